bus_tenure_scheduler: RTL and testbench

//  Decides which external DMA master gets the next bus tenure, and for how long. Masters are SDMAC or one of

---
 rtl/bus_arb_pkg.sv | 33 +++
 rtl/round_robin_priority_encoder.sv | 28 ++
 rtl/bus_tenure_scheduler.sv | 136 +++++++++++++
 tb/tb_bus_tenure_scheduler.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// Shared encodings for the bus-master scheduler and the pin-level bus arbitration block.
package bus_arb_pkg;

  localparam int NSLOTS_DEF = 5;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_GRANT     = 3'd1,
    ST_TENURE    = 3'd2,
    ST_PREEMPT   = 3'd3,
    ST_CPU_SLICE = 3'd4
  } sched_state_e;

  // Who currently masters the bus, as seen by bus_arbitration.
  typedef enum logic [1:0] {
    BM_CPU   = 2'd0,
    BM_SDMAC = 2'd1,
    BM_SLOT  = 2'd2
  } bus_master_e;

  // Handshake phase codes reported by bus_arbitration.
  localparam logic [1:0] BA_IDLE    = 2'd0;
  localparam logic [1:0] BA_REQ     = 2'd1;
  localparam logic [1:0] BA_GRANTED = 2'd2;
  localparam logic [1:0] BA_OWNED   = 2'd3;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/round_robin_priority_encoder.sv
// Picks the first requester strictly after last, wrapping; last itself is picked only if alone.
module round_robin_priority_encoder #(
  parameter int N  = 5,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          valid,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] j;

  // Walk offsets from farthest to nearest so the nearest requester overwrites.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    j     = '0;
    for (int k = N; k >= 1; k--) begin
      j = IW'((int'(last) + k) % N);
      if (req[j]) begin
        valid = 1'b1;
        idx   = j;
      end
    end
  end

endmodule

// File: rtl/bus_tenure_scheduler.sv
// Chooses the next DMA bus master (SDMAC or a Zorro slot) and times its tenure,
// enforcing ack timeout, slot preemption and a CPU slice between tenures.
module bus_tenure_scheduler
  import bus_arb_pkg::*;
#(
  parameter int NSLOTS      = NSLOTS_DEF,
  parameter int MAX_TENURE  = 64,
  parameter int CPU_SLICE   = 4,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic              clk100,
  input  logic              reset_n,
  input  logic              cpuclk_rising,
  input  logic              sdmac_req,
  input  logic [NSLOTS-1:0] slot_req,
  input  logic              owner_active,
  output logic [NSLOTS-1:0] grant,
  output logic              grant_sdmac,
  output logic              preempt,
  output logic              sched_busy,
  output logic              timeout_err
);

  localparam int  CW      = $clog2(max3(MAX_TENURE, CPU_SLICE, ACK_TIMEOUT) + 1);
  localparam int  IW      = (NSLOTS > 1) ? $clog2(NSLOTS) : 1;
  localparam bit  PRE_EN  = (MAX_TENURE != 0);
  localparam logic [CW-1:0] CNT_SAT = '1;

  sched_state_e      state, state_nx;
  logic [CW-1:0]     cnt;
  logic [IW-1:0]     last_grant, last_nx, pick;
  logic              pick_vld;
  logic [NSLOTS-1:0] pick_onehot;
  logic [NSLOTS-1:0] grant_nx;
  logic              gsd_nx, preempt_nx, tout_nx;
  logic              req_held, pending;

  round_robin_priority_encoder #(.N(NSLOTS), .IW(IW)) u_rr (
    .req   (slot_req),
    .last  (last_grant),
    .valid (pick_vld),
    .idx   (pick)
  );

  for (genvar i = 0; i < NSLOTS; i++) begin : g_oh
    assign pick_onehot[i] = (pick == IW'(i));
  end

  assign req_held   = grant_sdmac ? sdmac_req : |(slot_req & grant);
  assign pending    = sdmac_req | (|(slot_req & ~grant));
  assign sched_busy = (state != ST_IDLE);

  // State, counter and registered outputs.
  always_ff @(posedge clk100 or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      last_grant  <= IW'(NSLOTS - 1);
      grant       <= '0;
      grant_sdmac <= 1'b0;
      preempt     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nx;
      last_grant  <= last_nx;
      grant       <= grant_nx;
      grant_sdmac <= gsd_nx;
      preempt     <= preempt_nx;
      timeout_err <= tout_nx;
      // Every state entry restarts the count, even if a CPU edge lands that cycle.
      if (state_nx != state)
        cnt <= '0;
      else if (cpuclk_rising && cnt != CNT_SAT)
        cnt <= cnt + CW'(1);
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:
        if (sdmac_req || pick_vld) state_nx = ST_GRANT;
      ST_GRANT:
        if (owner_active)                      state_nx = ST_TENURE;
        else if (!req_held)                    state_nx = ST_IDLE;
        else if (cnt == CW'(ACK_TIMEOUT))      state_nx = ST_CPU_SLICE;
      ST_TENURE:
        if (!owner_active)                     state_nx = ST_CPU_SLICE;
        else if (PRE_EN && !grant_sdmac && cnt >= CW'(MAX_TENURE) && pending)
                                               state_nx = ST_PREEMPT;
      ST_PREEMPT:
        if (!owner_active)                     state_nx = ST_CPU_SLICE;
      ST_CPU_SLICE:
        if (cnt == CW'(CPU_SLICE))             state_nx = ST_IDLE;
      default:                                 state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    grant_nx   = grant;
    gsd_nx     = grant_sdmac;
    preempt_nx = 1'b0;
    tout_nx    = 1'b0;
    last_nx    = last_grant;
    case (state)
      ST_IDLE:
        if (state_nx == ST_GRANT) begin
          if (sdmac_req) begin
            gsd_nx = 1'b1;
          end else begin
            grant_nx = pick_onehot;
            last_nx  = pick;
          end
        end
      ST_GRANT, ST_TENURE: begin
        // Grant survives only the GRANT->TENURE hand-over.
        if (state_nx != state && state_nx != ST_TENURE) begin
          grant_nx = '0;
          gsd_nx   = 1'b0;
        end
        preempt_nx = (state_nx == ST_PREEMPT);
        tout_nx    = (state == ST_GRANT) && (state_nx == ST_CPU_SLICE);
      end
      ST_PREEMPT: begin
        grant_nx   = '0;
        gsd_nx     = 1'b0;
        preempt_nx = (state_nx == ST_PREEMPT);
      end
      default: begin
        grant_nx = '0;
        gsd_nx   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_bus_tenure_scheduler.sv
// Directed + randomized checks of bus_tenure_scheduler against a tenure-level reference model.
module tb_bus_tenure_scheduler;

  localparam int NS      = 5;
  localparam int CPU_DIV = 4;

  logic          clk100 = 1'b0;
  logic          reset_n;
  logic          cpuclk_rising;
  logic          sdmac_req;
  logic [NS-1:0] slot_req;
  logic          owner_active;
  logic [NS-1:0] grant;
  logic          grant_sdmac, preempt, sched_busy, timeout_err;

  int errors = 0;
  int checks = 0;
  int edges  = 0;
  int div    = 0;
  int model_last = NS - 1;

  always #5 clk100 = ~clk100;

  bus_tenure_scheduler dut (
    .clk100        (clk100),
    .reset_n       (reset_n),
    .cpuclk_rising (cpuclk_rising),
    .sdmac_req     (sdmac_req),
    .slot_req      (slot_req),
    .owner_active  (owner_active),
    .grant         (grant),
    .grant_sdmac   (grant_sdmac),
    .preempt       (preempt),
    .sched_busy    (sched_busy),
    .timeout_err   (timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Round-robin reference: nearest requester after last, wrapping.
  function automatic int rr(input logic [NS-1:0] req, input int last);
    for (int k = 1; k <= NS; k++)
      if (req[(last + k) % NS]) return (last + k) % NS;
    return -1;
  endfunction

  function automatic logic sig(input int which);
    case (which)
      0:       return sched_busy;
      1:       return preempt;
      2:       return timeout_err;
      default: return |grant;
    endcase
  endfunction

  // One clk100 cycle; counts CPU edges the DUT actually sampled and checks the grant invariant.
  task automatic tick();
    logic s;
    logic [NS:0] all;
    s = cpuclk_rising;
    @(posedge clk100);
    #1;
    if (s) edges++;
    div = (div + 1) % CPU_DIV;
    cpuclk_rising = (div == 0);
    all = {grant, grant_sdmac};
    chk("invariant", {31'd0, ($countones(all) <= 1) && (!preempt || all == '0)}, 32'd1);
  endtask

  task automatic run_edges(input int n);
    int e0;
    e0 = edges;
    while (edges - e0 < n) tick();
  endtask

  task automatic wait_sig(input string tag, input int which, input logic val, input int bound);
    int n;
    n = 0;
    while (sig(which) !== val && n < bound) begin
      tick();
      n++;
    end
    chk({tag, " reached"}, {31'd0, sig(which)}, {31'd0, val});
  endtask

  // Full tenure: request, grant, own for hold edges, release, then a 4-edge CPU slice.
  task automatic tenure(input string tag, input logic sd, input logic [NS-1:0] req, input int hold);
    logic [NS-1:0] eg;
    int p, e0;
    sdmac_req = sd;
    slot_req  = req;
    tick();
    eg = '0;
    if (!sd) begin
      p = rr(req, model_last);
      eg[p] = 1'b1;
      model_last = p;
    end
    chk({tag, " grant"}, {27'd0, grant}, {27'd0, eg});
    chk({tag, " grant_sdmac"}, {31'd0, grant_sdmac}, {31'd0, sd});
    owner_active = 1'b1;
    tick();
    run_edges(hold);
    chk({tag, " held"}, {26'd0, grant, grant_sdmac}, {26'd0, eg, sd});
    owner_active = 1'b0;
    sdmac_req    = 1'b0;
    slot_req     = '0;
    tick();
    chk({tag, " released"}, {26'd0, grant, grant_sdmac}, 32'd0);
    e0 = edges;
    wait_sig({tag, " idle"}, 0, 1'b0, 200);
    chk({tag, " slice edges"}, edges - e0, 32'd4);
  endtask

  initial begin
    int e0, hold;
    logic seen, sd;
    logic [NS-1:0] req;
    reset_n = 1'b0; cpuclk_rising = 1'b0; sdmac_req = 1'b0;
    slot_req = '0;  owner_active = 1'b0;
    tick(); tick();
    chk("rst grant", {27'd0, grant}, 32'd0);
    chk("rst flags", {28'd0, grant_sdmac, preempt, sched_busy, timeout_err}, 32'd0);
    reset_n = 1'b1;
    tick();

    // 1: single slot tenure
    tenure("t1", 1'b0, 5'b00100, 10);

    // 2: alternation between slots 4 and 0 after slot 0 went last
    tenure("t2a", 1'b0, 5'b00001, 2);
    tenure("t2b", 1'b0, 5'b10001, 3);
    chk("t2b slot4 first", model_last, 32'd4);
    tenure("t2c", 1'b0, 5'b10001, 3);
    tenure("t2d", 1'b0, 5'b10001, 3);

    // 3: SDMAC priority, never preempted
    sdmac_req = 1'b1; slot_req = 5'b00100;
    tick();
    chk("t3 grant_sdmac", {31'd0, grant_sdmac}, 32'd1);
    chk("t3 grant", {27'd0, grant}, 32'd0);
    owner_active = 1'b1;
    tick();
    seen = 1'b0;
    e0 = edges;
    while (edges - e0 < 200) begin
      tick();
      seen |= preempt;
    end
    chk("t3 no preempt", {31'd0, seen}, 32'd0);
    chk("t3 still sdmac", {31'd0, grant_sdmac}, 32'd1);
    owner_active = 1'b0; sdmac_req = 1'b0; slot_req = '0;
    tick();
    wait_sig("t3 idle", 0, 1'b0, 200);

    // 4: slot 1 preempted by slot 3 at 64 edges
    slot_req = 5'b00010;
    tick();
    chk("t4 grant1", {27'd0, grant}, 32'b00010);
    owner_active = 1'b1; slot_req = 5'b01010;
    tick();
    e0 = edges;
    wait_sig("t4 preempt", 1, 1'b1, 2000);
    chk("t4 preempt edges", edges - e0, 32'd64);
    chk("t4 grant cleared", {27'd0, grant}, 32'd0);
    run_edges(3);
    chk("t4 preempt held", {31'd0, preempt}, 32'd1);
    owner_active = 1'b0; slot_req = 5'b01000;
    tick();
    chk("t4 preempt drop", {31'd0, preempt}, 32'd0);
    e0 = edges;
    wait_sig("t4 regrant", 3, 1'b1, 200);
    chk("t4 slice edges", edges - e0, 32'd4);
    chk("t4 grant3", {27'd0, grant}, 32'b01000);
    model_last = 3;
    slot_req = '0;
    tick();
    chk("t4 req drop idle", {31'd0, sched_busy}, 32'd0);

    // 5: ack timeout
    slot_req = 5'b00100;
    tick();
    model_last = 2;
    chk("t5 grant", {27'd0, grant}, 32'b00100);
    e0 = edges;
    wait_sig("t5 timeout", 2, 1'b1, 400);
    chk("t5 timeout edges", edges - e0, 32'd16);
    chk("t5 grant cleared", {27'd0, grant}, 32'd0);
    e0 = edges;
    slot_req = '0;
    tick();
    chk("t5 pulse width", {31'd0, timeout_err}, 32'd0);
    wait_sig("t5 idle", 0, 1'b0, 200);
    chk("t5 slice edges", edges - e0, 32'd4);

    // 6: reset while preempting
    slot_req = 5'b01000;
    tick();
    owner_active = 1'b1; slot_req = 5'b01001;
    tick();
    wait_sig("t6 preempt", 1, 1'b1, 2000);
    #3 reset_n = 1'b0;
    #1;
    chk("t6 async clear", {25'd0, grant, grant_sdmac, preempt, sched_busy}, 32'd0);
    model_last = NS - 1;
    tick();
    reset_n = 1'b1; owner_active = 1'b0; slot_req = 5'b11111;
    tick();
    chk("t6 slot0 first", {27'd0, grant}, 32'b00001);
    model_last = 0;
    slot_req = '0;
    tick();
    chk("t6 drop no slice", {31'd0, sched_busy}, 32'd0);

    // Randomized tenures against the model
    for (int it = 0; it < 40; it++) begin
      sd   = ($urandom_range(0, 3) == 0);
      req  = NS'($urandom_range(1, 31));
      hold = $urandom_range(1, 20);
      if ($urandom_range(0, 4) == 0 && !sd) begin
        slot_req = req;
        tick();
        e0 = rr(req, model_last);
        model_last = e0;
        chk("rnd abort grant", {27'd0, grant}, 32'd1 << e0);
        slot_req = '0;
        tick();
        chk("rnd abort idle", {26'd0, grant, sched_busy}, 32'd0);
      end else begin
        tenure("rnd", sd, req, hold);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
